// File: rtl/ysyx_25060166_ifetch.sv
// Multi-cycle instruction fetch: one memory read per PC, result held for the IDU under valid/ready.
// Optional YSYX_25060166_IFETCH_MISALIGN_EN: misaligned PCs skip memory and report out_misalign_o.
`ifndef ysyx_25060166_WIDTH
`define ysyx_25060166_WIDTH 32
`endif

module ysyx_25060166_ifetch #(
  parameter int WIDTH = `ysyx_25060166_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pc_i,
  input  logic             flush_i,
  output logic             pc_advance_o,
  output logic             mem_req_valid_o,
  input  logic             mem_req_ready_i,
  output logic [WIDTH-1:0] mem_req_addr_o,
  input  logic             mem_rsp_valid_i,
  input  logic [31:0]      mem_rsp_data_i,
  input  logic             mem_rsp_err_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      out_inst_o,
  output logic [WIDTH-1:0] out_pc_o,
  output logic             out_acc_fault_o,
  output logic             out_misalign_o
);

  typedef enum logic [1:0] {REQ, WAIT, HOLD, DRAIN} state_t;

  state_t           state;
  logic [WIDTH-1:0] pc_q;
  logic [31:0]      inst_q;
  logic             fault_q;
  logic             valid_q;
  logic             misalign;

`ifdef YSYX_25060166_IFETCH_MISALIGN_EN
  logic misalign_q;
  assign misalign       = |pc_i[1:0];
  assign out_misalign_o = misalign_q && !reset;
`else
  assign misalign       = 1'b0;
  assign out_misalign_o = 1'b0;
`endif

  // Outputs are forced low while reset is asserted, before the registers clear.
  assign mem_req_valid_o = (state == REQ) && !reset && !flush_i && !misalign;
  assign mem_req_addr_o  = reset ? '0 : pc_i;
  assign out_valid_o     = valid_q && !reset;
  assign out_inst_o      = reset ? '0 : inst_q;
  assign out_pc_o        = reset ? '0 : pc_q;
  assign out_acc_fault_o = fault_q && !reset;
  assign pc_advance_o    = out_valid_o && out_ready_i && !flush_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= REQ;
      pc_q    <= '0;
      inst_q  <= '0;
      fault_q <= 1'b0;
      valid_q <= 1'b0;
`ifdef YSYX_25060166_IFETCH_MISALIGN_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      case (state)
        REQ: begin
          if (!flush_i) begin
            if (misalign) begin
`ifdef YSYX_25060166_IFETCH_MISALIGN_EN
              pc_q       <= pc_i;
              inst_q     <= '0;
              fault_q    <= 1'b0;
              misalign_q <= 1'b1;
              valid_q    <= 1'b1;
              state      <= HOLD;
`endif
            end else if (mem_req_ready_i) begin
              pc_q  <= pc_i;
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (mem_rsp_valid_i) begin
            if (flush_i) begin
              state <= REQ;
            end else begin
              inst_q  <= mem_rsp_err_i ? 32'h0 : mem_rsp_data_i;
              fault_q <= mem_rsp_err_i;
              valid_q <= 1'b1;
`ifdef YSYX_25060166_IFETCH_MISALIGN_EN
              misalign_q <= 1'b0;
`endif
              state   <= HOLD;
            end
          end else if (flush_i) begin
            state <= DRAIN;
          end
        end
        // The orphaned response still has to come back before a new request goes out.
        DRAIN: begin
          if (mem_rsp_valid_i) state <= REQ;
        end
        HOLD: begin
          if (flush_i || out_ready_i) begin
            valid_q <= 1'b0;
            state   <= REQ;
          end
        end
        default: state <= REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25060166_ifetch.sv
// Directed checks for reset/latency/flush cases, then randomized traffic against a fetch scoreboard.
module tb_ysyx_25060166_ifetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_i;
  logic        flush_i;
  logic        pc_advance_o;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic [31:0] mem_req_addr_o;
  logic        mem_rsp_valid_i;
  logic [31:0] mem_rsp_data_i;
  logic        mem_rsp_err_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_inst_o;
  logic [31:0] out_pc_o;
  logic        out_acc_fault_o;
  logic        out_misalign_o;

  ysyx_25060166_ifetch dut (
    .clk(clk), .reset(reset), .pc_i(pc_i), .flush_i(flush_i), .pc_advance_o(pc_advance_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_addr_o(mem_req_addr_o), .mem_rsp_valid_i(mem_rsp_valid_i),
    .mem_rsp_data_i(mem_rsp_data_i), .mem_rsp_err_i(mem_rsp_err_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_inst_o(out_inst_o),
    .out_pc_o(out_pc_o), .out_acc_fault_o(out_acc_fault_o), .out_misalign_o(out_misalign_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   handshakes = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every presented instruction must match the oldest surviving fetch.
  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid_o) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_out_valid actual=1 expected=0 @%0t", $time);
        end else begin
          chk("out_inst", {32'h0, out_inst_o}, {32'h0, sb[0].inst});
          chk("out_pc", {32'h0, out_pc_o}, {32'h0, sb[0].pc});
          chk("out_fault", {63'h0, out_acc_fault_o}, {63'h0, sb[0].fault});
          if (out_ready_i || flush_i) void'(sb.pop_front());
          if (out_ready_i && !flush_i) handshakes++;
        end
      end
      chk("pc_advance", {63'h0, pc_advance_o}, {63'h0, out_valid_o && out_ready_i && !flush_i});
      chk("misalign_flag", {63'h0, out_misalign_o}, 64'h0);
    end
  end

  // Memory and IFU reference state for the random phase.
  logic [31:0] ifu_pc, req_pc, rsp_data;
  bit          busy, cancel, rsp_err, misal_ok;
  int          lat;

  initial begin
    reset = 1'b1; pc_i = '0; flush_i = 1'b0; mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b0; mem_rsp_data_i = '0; mem_rsp_err_i = 1'b0; out_ready_i = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_req_valid", {63'h0, mem_req_valid_o}, 64'h0);
      chk("rst_out_valid", {63'h0, out_valid_o}, 64'h0);
      chk("rst_outs", {out_inst_o, out_pc_o}, 64'h0);
      chk("rst_flags", {61'h0, pc_advance_o, out_acc_fault_o, out_misalign_o}, 64'h0);
    end

    // Basic fetch with IDU backpressure.
    step(); reset = 1'b0; pc_i = 32'h8000_0000; mem_req_ready_i = 1'b1;
    @(negedge clk);
    chk("first_req_valid", {63'h0, mem_req_valid_o}, 64'h1);
    chk("first_req_addr", {32'h0, mem_req_addr_o}, 64'h8000_0000);
    step(); mem_rsp_valid_i = 1'b1; mem_rsp_data_i = 32'h0010_0093; mem_req_ready_i = 1'b0;
    @(negedge clk);
    chk("wait_out_valid", {63'h0, out_valid_o}, 64'h0);
    step(); mem_rsp_valid_i = 1'b0; mem_rsp_data_i = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", {63'h0, out_valid_o}, 64'h1);
      chk("bp_data", {out_inst_o, out_pc_o}, {32'h0010_0093, 32'h8000_0000});
      chk("bp_quiet", {62'h0, mem_req_valid_o, pc_advance_o}, 64'h0);
      step();
    end
    out_ready_i = 1'b1;
    @(negedge clk);
    chk("advance_pulse", {63'h0, pc_advance_o}, 64'h1);

    // Access fault response.
    step(); out_ready_i = 1'b0; pc_i = 32'h8000_0004; mem_req_ready_i = 1'b1;
    @(negedge clk);
    chk("req2_addr", {31'h0, mem_req_valid_o, mem_req_addr_o}, {31'h0, 1'b1, 32'h8000_0004});
    step(); mem_rsp_valid_i = 1'b1; mem_rsp_err_i = 1'b1; mem_rsp_data_i = 32'hdead_beef;
    mem_req_ready_i = 1'b0;
    step(); mem_rsp_valid_i = 1'b0; mem_rsp_err_i = 1'b0; mem_rsp_data_i = 32'h0;
    @(negedge clk);
    chk("err_valid_fault", {62'h0, out_valid_o, out_acc_fault_o}, 64'h3);
    chk("err_data", {out_inst_o, out_pc_o}, {32'h0, 32'h8000_0004});

    // Flush coincident with IDU ready in HOLD.
    step(); out_ready_i = 1'b1; flush_i = 1'b1;
    @(negedge clk);
    chk("hold_flush_noadv", {63'h0, pc_advance_o}, 64'h0);
    step(); out_ready_i = 1'b0; flush_i = 1'b0; pc_i = 32'h8000_0008; mem_req_ready_i = 1'b1;
    @(negedge clk);
    chk("after_hold_flush", {30'h0, out_valid_o, mem_req_valid_o, mem_req_addr_o},
        {30'h0, 2'b01, 32'h8000_0008});

    // Flush in WAIT, orphan response three cycles later.
    step(); flush_i = 1'b1; mem_req_ready_i = 1'b0;
    @(negedge clk);
    chk("wait_flush_noreq", {63'h0, mem_req_valid_o}, 64'h0);
    step(); flush_i = 1'b0; pc_i = 32'h8000_0100; mem_req_ready_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("drain_quiet", {62'h0, out_valid_o, mem_req_valid_o}, 64'h0);
      step();
    end
    mem_rsp_valid_i = 1'b1; mem_rsp_data_i = 32'h1111_1111;
    @(negedge clk);
    chk("drain_rsp_dropped", {62'h0, out_valid_o, mem_req_valid_o}, 64'h0);
    step(); mem_rsp_valid_i = 1'b0; mem_rsp_data_i = 32'h0; mem_req_ready_i = 1'b0;
    @(negedge clk);
    chk("post_drain_req", {30'h0, out_valid_o, mem_req_valid_o, mem_req_addr_o},
        {30'h0, 2'b01, 32'h8000_0100});

    // Misaligned PC.
    step(); pc_i = 32'h8000_0002;
`ifdef YSYX_25060166_IFETCH_MISALIGN_EN
    @(negedge clk);
    chk("misal_noreq", {63'h0, mem_req_valid_o}, 64'h0);
    step(); out_ready_i = 1'b1;
    @(negedge clk);
    chk("misal_flags", {61'h0, out_valid_o, out_misalign_o, pc_advance_o}, 64'h7);
    chk("misal_data", {out_inst_o, out_pc_o}, {32'h0, 32'h8000_0002});
    step(); out_ready_i = 1'b0; pc_i = 32'h8000_0100;
    misal_ok = 1'b0;
`else
    @(negedge clk);
    chk("misal_req", {31'h0, mem_req_valid_o, mem_req_addr_o}, {31'h0, 1'b1, 32'h8000_0002});
    chk("misal_tied", {63'h0, out_misalign_o}, 64'h0);
    step(); pc_i = 32'h8000_0100;
    misal_ok = 1'b1;
`endif

    // Randomized traffic.
    ifu_pc = 32'h8000_0100; busy = 1'b0; cancel = 1'b0; lat = 0;
    req_pc = '0; rsp_data = '0; rsp_err = 1'b0;
    mon_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      step();
      flush_i         = ($urandom_range(0, 11) == 0);
      out_ready_i     = ($urandom_range(0, 2) != 0);
      mem_req_ready_i = ($urandom_range(0, 3) != 0);
      mem_rsp_valid_i = busy && (lat == 0);
      mem_rsp_data_i  = mem_rsp_valid_i ? rsp_data : $urandom;
      mem_rsp_err_i   = mem_rsp_valid_i ? rsp_err : 1'($urandom_range(0, 1));
      pc_i            = ifu_pc;
      @(negedge clk);
      if (mem_req_valid_o) begin
        chk("rnd_req_addr", {32'h0, mem_req_addr_o}, {32'h0, ifu_pc});
        chk("rnd_one_outstanding", {63'h0, busy}, 64'h0);
        chk("rnd_req_no_flush", {63'h0, flush_i}, 64'h0);
      end
      if (mem_rsp_valid_i) begin
        busy = 1'b0;
        if (!cancel && !flush_i)
          sb.push_back('{inst: rsp_err ? 32'h0 : rsp_data, pc: req_pc, fault: rsp_err});
      end else if (busy) begin
        if (flush_i) cancel = 1'b1;
        if (lat > 0) lat--;
      end
      if (mem_req_valid_o && mem_req_ready_i) begin
        busy = 1'b1; cancel = 1'b0; lat = $urandom_range(0, 3);
        rsp_data = $urandom; rsp_err = ($urandom_range(0, 7) == 0); req_pc = ifu_pc;
      end
      if (flush_i)
        ifu_pc = 32'h8000_0000 + ($urandom_range(0, 255) << 2) +
                 ((misal_ok && $urandom_range(0, 7) == 0) ? 32'd2 : 32'd0);
      else if (pc_advance_o)
        ifu_pc = ifu_pc + 32'd4;
    end
    mon_en = 1'b0;
    chk("progress", {63'h0, handshakes >= 50}, 64'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
